// File: rtl/prog_loader.sv
// Byte-stream program loader: receives a big-endian word count and that many
// 32-bit big-endian words, writing them to instruction memory while holding the CPU.
module prog_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WR, S_DONE, S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [23:0]       word_q, word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              in_ready_q, im_we_q, cpu_hold_q, done_q, error_q;
    logic              accept;
    logic [15:0]       n_len;

    assign accept = in_valid && in_ready_q;
    assign n_len  = {len_q[15:8], in_data};

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        word_d  = word_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_LEN_HI;
            S_LEN_HI: if (accept) begin
                len_d[15:8] = in_data;
                state_d     = S_LEN_LO;
            end
            S_LEN_LO: if (accept) begin
                len_d  = n_len;
                idx_d  = '0;
                bcnt_d = '0;
                if (n_len == 16'd0)
                    state_d = S_DONE;
                else if (32'(n_len) > (32'd1 << ADDR_W))
                    state_d = S_ERR;
                else
                    state_d = S_DATA;
            end
            S_DATA: if (accept) begin
                bcnt_d = bcnt_q + 2'd1;
                if (bcnt_q == 2'd3) begin
                    wdata_d = {word_q, in_data};
                    addr_d  = idx_q[ADDR_W-1:0];
                    state_d = S_WR;
                end else begin
                    word_d = {word_q[15:0], in_data};
                end
            end
            // Index is one bit wider than the address so N = 2^ADDR_W terminates.
            S_WR: begin
                idx_d   = idx_q + 1'b1;
                state_d = (32'(idx_q) + 32'd1 == 32'(len_q)) ? S_DONE : S_DATA;
            end
            S_DONE, S_ERR: if (start) state_d = S_LEN_HI;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            idx_q      <= '0;
            bcnt_q     <= '0;
            word_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            in_ready_q <= 1'b0;
            im_we_q    <= 1'b0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            bcnt_q     <= bcnt_d;
            word_q     <= word_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            // Status outputs are registered from the next state so they align with it.
            in_ready_q <= (state_d inside {S_LEN_HI, S_LEN_LO, S_DATA});
            im_we_q    <= (state_d == S_WR);
            cpu_hold_q <= (state_d != S_DONE);
            done_q     <= (state_d == S_DONE);
            error_q    <= (state_d == S_ERR);
        end
    end

    assign in_ready = in_ready_q;
    assign im_we    = im_we_q;
    assign im_addr  = addr_q;
    assign im_wdata = wdata_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: a transaction-level model predicts every
// memory write and the final status of each load.
module tb_prog_loader;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst, start, in_valid;
    logic [7:0]        in_data;
    logic              in_ready, im_we, cpu_hold, done, error;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    wr_t               expq[$];
    int                vectors = 0;
    int                miscompares = 0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic [31:0]       last_wdata = '0;

    prog_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle: each write must be the next predicted one; otherwise the bus holds.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            last_addr  = '0;
            last_wdata = '0;
            chk("rst_im_we", 32'(im_we), 0);
            chk("rst_im_addr", 32'(im_addr), 0);
        end else if (im_we) begin
            if (expq.size() == 0) begin
                chk("unexpected_write_addr", 32'(im_addr), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = expq.pop_front();
                chk("write_addr", 32'(im_addr), 32'(e.a));
                chk("write_data", im_wdata, e.d);
                chk("we_in_ready", 32'(in_ready), 0);
            end
            last_addr  = im_addr;
            last_wdata = im_wdata;
        end else begin
            chk("hold_addr", 32'(im_addr), 32'(last_addr));
            chk("hold_data", im_wdata, last_wdata);
        end
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("start_cpu_hold", 32'(cpu_hold), 1);
        chk("start_done", 32'(done), 0);
        chk("start_error", 32'(error), 0);
        chk("start_in_ready", 32'(in_ready), 1);
    endtask

    task automatic send_seq(input logic [7:0] b[$], input bit gaps, input int start_at);
        for (int i = 0; i < b.size(); i++) begin
            int w;
            if (i == start_at) begin
                @(negedge clk); in_valid = 1'b0; start = 1'b1;
                @(negedge clk); start = 1'b0;
            end
            if (gaps) begin
                int g;
                g = $urandom_range(0, 3);
                repeat (g) begin
                    @(negedge clk); in_valid = 1'b0; in_data = 8'($urandom);
                end
            end
            @(negedge clk); in_valid = 1'b1; in_data = b[i];
            w = 0;
            while (!in_ready && w < 100) begin
                @(negedge clk); w++;
            end
            if (!in_ready) begin
                chk("in_ready_timeout", 32'(in_ready), 1);
                in_valid = 1'b0;
                break;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic run_bytes(input logic [7:0] b[$], input bit gaps, input int start_at,
                             input bit legal);
        int w;
        pulse_start();
        send_seq(b, gaps, start_at);
        w = 0;
        while (!(done || error) && w < 20) begin
            @(negedge clk); w++;
        end
        @(negedge clk);
        chk("end_done", 32'(done), legal ? 1 : 0);
        chk("end_error", 32'(error), legal ? 0 : 1);
        chk("end_cpu_hold", 32'(cpu_hold), legal ? 0 : 1);
        chk("end_in_ready", 32'(in_ready), 0);
        chk("writes_outstanding", 32'(expq.size()), 0);
    endtask

    // Model: split the count and random words into the big-endian byte stream.
    task automatic load(input int n, input bit gaps, input int start_at);
        logic [7:0] b[$];
        logic [31:0] w;
        bit legal;
        legal = (n <= (1 << ADDR_W));
        b.push_back(8'(n / 256));
        b.push_back(8'(n % 256));
        if (legal) begin
            for (int i = 0; i < n; i++) begin
                w = $urandom;
                expq.push_back('{a: ADDR_W'(i), d: w});
                b.push_back(8'(w / 32'h100_0000));
                b.push_back(8'((w / 32'h1_0000) % 256));
                b.push_back(8'((w / 32'h100) % 256));
                b.push_back(8'(w % 256));
            end
        end
        run_bytes(b, gaps, start_at, legal);
    endtask

    initial begin
        logic [7:0] b[$];
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        #12;
        chk("reset_in_ready", 32'(in_ready), 0);
        chk("reset_im_we", 32'(im_we), 0);
        chk("reset_im_addr", 32'(im_addr), 0);
        chk("reset_im_wdata", im_wdata, 0);
        chk("reset_cpu_hold", 32'(cpu_hold), 1);
        chk("reset_done", 32'(done), 0);
        chk("reset_error", 32'(error), 0);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_cpu_hold", 32'(cpu_hold), 1);
        chk("idle_in_ready", 32'(in_ready), 0);

        // Two-word program with hand-computed words.
        b = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
        expq.push_back('{a: 8'h00, d: 32'h2008_0005});
        expq.push_back('{a: 8'h01, d: 32'h0109_5020});
        run_bytes(b, 1'b0, -1, 1'b1);
        chk("lit_last_addr", 32'(im_addr), 32'h01);
        chk("lit_last_data", im_wdata, 32'h0109_5020);

        load(0, 1'b0, -1);

        // Oversized length, error stays until the next start.
        load(257, 1'b0, -1);
        repeat (5) @(negedge clk);
        chk("err_sticky", 32'(error), 1);
        chk("err_hold", 32'(cpu_hold), 1);
        load(3, 1'b1, -1);

        for (int k = 0; k < 4; k++) load(1, 1'b1, -1);
        load($urandom_range(2, 8), 1'b1, -1);

        // Reset after the second data byte of a one-word load.
        pulse_start();
        b = '{8'h00, 8'h01, 8'hAA, 8'hBB};
        send_seq(b, 1'b0, -1);
        #2 rst = 1'b1;
        #1;
        chk("abort_im_we", 32'(im_we), 0);
        chk("abort_cpu_hold", 32'(cpu_hold), 1);
        chk("abort_in_ready", 32'(in_ready), 0);
        chk("abort_done", 32'(done), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_idle_in_ready", 32'(in_ready), 0);
        load(1, 1'b0, -1);

        // Full memory, with an ignored start pulse in the middle of the data.
        load(256, 1'b0, 2 + 4 * 10 + 1);
        chk("full_last_addr", 32'(im_addr), 32'hFF);

        for (int k = 0; k < 10; k++) begin
            if ($urandom_range(0, 3) == 0) load($urandom_range(257, 65535), 1'b1, -1);
            else load($urandom_range(0, 20), 1'b1, -1);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning instruction-memory word-address width (depth 2^ADDR_W words).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset: asynchronous and active-high.
REQ-004 SHALL have port start, input, 1, load-request pulse.
REQ-005 SHALL have port in_valid, input, 1, the byte-stream source has a byte.
REQ-006 SHALL have port in_data, input, 8, the stream byte.
REQ-007 SHALL have port in_ready, output, 1, the loader accepts a byte; transfer occurs when in_valid && in_ready at a clk edge.
REQ-008 SHALL have port im_we, output, 1, instruction-memory write strobe.
REQ-009 SHALL have port im_addr, output, ADDR_W, instruction-memory word address.
REQ-010 SHALL have port im_wdata, output, 32, instruction word.
REQ-011 SHALL have port cpu_hold, output, 1, holds the CPU (PC and fetch) while high.
REQ-012 SHALL have port done, output, 1, load completed successfully.
REQ-013 SHALL have port error, output, 1, the length exceeded memory depth.

Function
REQ-014 SHALL implement states IDLE, LEN_HI, LEN_LO, DATA, WR, DONE, ERR; all outputs are registered or decoded from state.
REQ-015 IDLE: in_ready=0, cpu_hold=1; start=1 -> LEN_HI.
REQ-016 LEN_HI/LEN_LO: in_ready=1; accepted bytes form a 16-bit big-endian word count N (LEN_HI byte = N[15:8]).
REQ-017 On the LEN_LO accept: N=0 -> DONE; N > 2^ADDR_W -> ERR; otherwise -> DATA with word index 0 and byte count 0.
REQ-018 DATA: in_ready=1; bytes assemble big-endian, first byte -> im_wdata[31:24], fourth -> [7:0]; the 2-bit byte count wraps 3->0.
REQ-019 On the 4th byte accept: -> WR for exactly one cycle with im_we=1, im_addr=word index, im_wdata=assembled word, in_ready=0.
REQ-020 Leaving WR: the word index increments; if the incremented index equals N -> DONE, else -> DATA.
REQ-021 im_we SHALL be 1 only in WR; im_addr/im_wdata SHALL hold their last values outside WR.
REQ-022 DONE: done=1, cpu_hold=0, in_ready=0.
REQ-023 ERR: error=1, cpu_hold=1, in_ready=0; ERR is sticky until start or rst.
REQ-024 start in DONE or ERR -> LEN_HI, clearing done/error and setting cpu_hold=1 at the same edge.
REQ-025 start in LEN_HI, LEN_LO, DATA or WR SHALL be ignored.
REQ-026 in_valid=0 stalls any state without loss of partial word or count; bytes with in_ready=0 are not consumed.
REQ-027 N=2^ADDR_W is legal: the last write is at im_addr = all ones, and the word index SHALL be wide enough not to wrap before comparison.

Reset
REQ-028 While rst=1, asynchronously: state=IDLE, in_ready=0, im_we=0, im_addr=0, im_wdata=0, cpu_hold=1, done=0, error=0, and all counters 0.
REQ-029 rst mid-load SHALL abort immediately with no further im_we; a partial word is discarded.

Verification
REQ-030 Scenario: start, bytes 00 02 | 20 08 00 05 | 01 09 50 20 -> im_we at addr 0 data 20080005, then addr 1 data 01095020; done=1, cpu_hold=0.
REQ-031 Scenario: start, length 00 00 -> DONE with no im_we pulse; done=1.
REQ-032 Scenario (ADDR_W=8): length 01 01 -> error=1, cpu_hold=1, no writes; then start with a valid length loads normally.
REQ-033 Scenario: a random in_valid gap pattern across one word -> the same single write, with no duplicated or dropped bytes.
REQ-034 Scenario: rst asserted after the 2nd data byte -> im_we=0 immediately, cpu_hold=1, state=IDLE; then a restart with N=1 writes to addr 0.
REQ-035 Scenario: N=256 -> 256 writes to addrs 00..FF, then done=1; a start pulse during DATA has no effect.
